efuse_pgm_seq: RTL
==================

Name: efuse_pgm_seq

Overview:
- Program-cycle sequencer between the efuse read/write control block and the efuse macro.
- Accepts one NW-bit write request (start, bank select, data) and burns every '1' bit one at a time.
- Drives macro chip-select, program-enable, address and strobe with programmable setup, pulse and hold timing.
- Reports busy and done back to the requester; '0' bits are never strobed.

Parameters:
NW, 64, bits per write request; 256 must be divisible by NW
EFUSE_BITS, 256, total macro bits
T_SETUP, 4, cycles from csb/pgmen assertion to first scan; range 1..255
T_PGM, 100, strobe high cycles per programmed bit; range 1..255
T_HOLD, 4, cycles after strobe low, and after final bit before pgmen release; range 1..255

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
write_start  in  1  single-cycle request, sampled in IDLE only
write_sel  in  $clog2(EFUSE_BITS/NW)  bank select, latched at accepted start
write_data  in  NW  bits to burn, latched at accepted start
write_done  out  1  level; set on completion, cleared by next accepted start
efuse_busy_write  out  1  high while a request is in progress
prog_cnt  out  $clog2(NW+1)  bits strobed in the current/last request
efuse_csb  out  1  macro chip select, active low
efuse_pgmen  out  1  macro program enable (power switch)
efuse_strobe  out  1  macro program strobe
efuse_addr  out  $clog2(EFUSE_BITS)  macro bit address

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low. All state is in clk flops.
- Reset values: state IDLE, write_done=0, efuse_busy_write=0, prog_cnt=0, efuse_csb=1, efuse_pgmen=0, efuse_strobe=0, efuse_addr=0. All outputs are registered.
- Reset mid-operation: at the reset edge, strobe, pgmen and busy drop and csb goes high. No done is generated and the latched request is discarded.
- Accept: write_start high in IDLE latches data_q, sel_q, idx=0 and prog_cnt=0, and clears write_done.
  - data nonzero: next state is SETUP.
  - data zero: no macro activity, busy stays 0, write_done=1 on the next cycle.
- Ignored starts: write_start is ignored in every non-IDLE state. There is no queueing and no error flag.
- SETUP: busy=1, csb=0, pgmen=1. Lasts T_SETUP cycles, then SCAN.
- SCAN: exactly one cycle per index.
  - data_q[idx]=1: efuse_addr=sel_q*NW+idx, go to STROBE.
  - Else if idx==NW-1: go to FINISH.
  - Else: idx+1, stay in SCAN.
- STROBE: strobe=1 for T_PGM cycles; efuse_addr is stable throughout. prog_cnt increments on entry.
- HOLD: strobe=0 for T_HOLD cycles, efuse_addr held. Then idx==NW-1 goes to FINISH; otherwise idx+1 and SCAN.
- FINISH: csb=0, pgmen=1, strobe=0 for T_HOLD cycles. Then IDLE with csb=1, pgmen=0, busy=0 and write_done=1, all in the same cycle.
- Busy duration: with k≥1 set bits, busy is high for exactly T_SETUP + NW + k*(T_PGM+T_HOLD) + T_HOLD cycles.
- Addressing: strictly ascending, and never leaves bank sel_q. The address is bank×NW + index, with no wrap beyond bank × NW + NW-1.
- Timer: a single down-counter of width 8, loaded at each timed-state entry. Timed states exit when the counter reaches 1.
- Input isolation: changes to write_data or write_sel during busy have no effect.

Decomposition:
- efuse_pkg (shared) holds:
  - state enum pgm_state_e: IDLE, SETUP, SCAN, STROBE, HOLD, FINISH
  - EFUSE_BITS=256
  - EFUSE_ADDR_W=8
  - default timing constants
- The read-side sequencer reuses the same package.
- One sub-module, efuse_tmr: loadable 8-bit down-counter with a load value and an expire flag. The read sequencer will share it.

Test Plan (NW=64, T_SETUP=2, T_PGM=5, T_HOLD=2 unless noted):
1. sel=0, data=0x1, start → busy high 75 cycles. One 5-cycle strobe at addr 0, starting 3 cycles after busy rises. prog_cnt=1; write_done=1 as busy falls.
2. sel=3, data=0x8000_0000_0000_0000 → one strobe at addr 255; busy 75 cycles; csb low and pgmen high for the whole busy window.
3. sel=1, data=all ones → busy 516 cycles. 64 strobes at addrs 64..127 ascending, each followed by 2 low cycles. prog_cnt=64.
4. data=0 → busy never high, csb/pgmen/strobe never toggle, write_done=1 one cycle after start. Then data=0x3 → write_done clears the cycle after start.
5. Second write_start with new data/sel during STROBE → ignored. Only the first request's addresses are strobed and prog_cnt matches the first request.
6. rst_n low for one cycle during STROBE of bit 5 of data=0xFF → next cycle strobe=0, pgmen=0, csb=1, busy=0, write_done=0, prog_cnt=0. A fresh start afterwards works normally.

Source files
------------

// File: rtl/efuse_pkg.sv
// rtl/efuse_pkg.sv - shared efuse sequencer types and constants
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCAN,
        STROBE,
        HOLD,
        FINISH
    } pgm_state_e;

    localparam int EFUSE_BITS   = 256;
    localparam int EFUSE_ADDR_W = 8;
    localparam int TMR_W        = 8;

    localparam int DEF_T_SETUP  = 4;
    localparam int DEF_T_PGM    = 100;
    localparam int DEF_T_HOLD   = 4;

endpackage

// File: rtl/efuse_tmr.sv
// rtl/efuse_tmr.sv - loadable down-counter; expire marks the final cycle of a timed state
module efuse_tmr
    import efuse_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expire
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    // A load value of N gives exactly N cycles in the state before expire.
    assign expire = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/efuse_pgm_seq.sv
// rtl/efuse_pgm_seq.sv - efuse program sequencer: burns each set bit of one write request
module efuse_pgm_seq #(
    parameter int NW         = 64,
    parameter int EFUSE_BITS = efuse_pkg::EFUSE_BITS,
    parameter int T_SETUP    = efuse_pkg::DEF_T_SETUP,
    parameter int T_PGM      = efuse_pkg::DEF_T_PGM,
    parameter int T_HOLD     = efuse_pkg::DEF_T_HOLD
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              write_start,
    input  logic [$clog2(EFUSE_BITS/NW)-1:0]  write_sel,
    input  logic [NW-1:0]                     write_data,
    output logic                              write_done,
    output logic                              efuse_busy_write,
    output logic [$clog2(NW+1)-1:0]           prog_cnt,
    output logic                              efuse_csb,
    output logic                              efuse_pgmen,
    output logic                              efuse_strobe,
    output logic [$clog2(EFUSE_BITS)-1:0]     efuse_addr
);

    import efuse_pkg::*;

    localparam int IDX_W  = $clog2(NW);
    localparam int SEL_W  = $clog2(EFUSE_BITS / NW);
    localparam int ADDR_W = $clog2(EFUSE_BITS);
    localparam int CNT_W  = $clog2(NW + 1);

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(T_SETUP);
    localparam logic [TMR_W-1:0] PGM_LD   = TMR_W'(T_PGM);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(T_HOLD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);

    pgm_state_e        state_q, state_d;
    logic [NW-1:0]     data_q;
    logic [SEL_W-1:0]  sel_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] bit_addr;

    logic              accept;
    logic              idx_inc;
    logic              strobe_entry;
    logic              finish_exit;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expire;

    // Bank base plus index; NW divides the macro so this never leaves the bank.
    assign bit_addr = ADDR_W'(sel_q) * ADDR_W'(NW) + ADDR_W'(idx_q);

    efuse_tmr u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        idx_inc      = 1'b0;
        strobe_entry = 1'b0;
        finish_exit  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        unique case (state_q)
            IDLE: begin
                if (write_start) begin
                    accept = 1'b1;
                    if (write_data != '0) begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (tmr_expire) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (data_q[idx_q]) begin
                    state_d      = STROBE;
                    strobe_entry = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = PGM_LD;
                end else if (idx_q == IDX_LAST) begin
                    state_d  = FINISH;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            STROBE: begin
                if (tmr_expire) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    if (idx_q == IDX_LAST) begin
                        state_d  = FINISH;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else begin
                        state_d = SCAN;
                        idx_inc = 1'b1;
                    end
                end
            end
            FINISH: begin
                if (tmr_expire) begin
                    state_d     = IDLE;
                    finish_exit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Macro controls are registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            data_q           <= '0;
            sel_q            <= '0;
            idx_q            <= '0;
            prog_cnt         <= '0;
            write_done       <= 1'b0;
            efuse_busy_write <= 1'b0;
            efuse_csb        <= 1'b1;
            efuse_pgmen      <= 1'b0;
            efuse_strobe     <= 1'b0;
            efuse_addr       <= '0;
        end else begin
            state_q          <= state_d;
            efuse_busy_write <= (state_d != IDLE);
            efuse_csb        <= (state_d == IDLE);
            efuse_pgmen      <= (state_d != IDLE);
            efuse_strobe     <= (state_d == STROBE);
            if (accept) begin
                data_q     <= write_data;
                sel_q      <= write_sel;
                idx_q      <= '0;
                prog_cnt   <= '0;
                write_done <= (write_data == '0);
            end
            if (idx_inc) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (strobe_entry) begin
                prog_cnt   <= prog_cnt + CNT_W'(1);
                efuse_addr <= bit_addr;
            end
            if (finish_exit) begin
                write_done <= 1'b1;
            end
        end
    end

endmodule
